// File: rtl/data_sram_if.sv
// Data-SRAM request/response bus between a load/store pipeline stage and the
// SRAM slave. The master issues requests; the slave accepts and answers them.
interface data_sram_if;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_req, data_sram_wr, data_sram_size,
               data_sram_addr, data_sram_wdata,
        input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );

    modport slave (
        input  data_sram_req, data_sram_wr, data_sram_size,
               data_sram_addr, data_sram_wdata,
        output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );
endinterface

// File: rtl/data_sram_slave.sv
// Fixed-latency data SRAM slave: 2^ADDR_W 32-bit words, at most two requests
// in flight, responses exactly LATENCY (1..7) cycles after acceptance, in order.
// The memory access itself happens in the response cycle, so a read accepted
// after a write to the same word always observes that write.
module data_sram_slave #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 1
) (
    input logic        clk,
    input logic        reset,
    data_sram_if.slave bus
);

    typedef struct packed {
        logic              wr;
        logic              ok;     // aligned and legal size; misaligned ops touch nothing
        logic [3:0]        be;
        logic [ADDR_W-1:0] idx;
        logic [31:0]       wdata;
    } req_t;

    logic [1:0]       count;
    logic             accept;
    logic             retire;
    logic             data_ok;
    logic [LATENCY:1] vld_pipe;
    req_t             req_pipe [1:LATENCY];
    req_t             req_in;
    req_t             req_out;
    logic [3:0]       be;
    logic             aligned;
    logic [31:0]      rdata;
    logic [31:0]      mem [0:(1<<ADDR_W)-1];
    logic             unused_addr;

    // Address bits above the word index are ignored, so the array wraps.
    assign unused_addr = ^bus.data_sram_addr;

    // No retire bypass: a full slot frees up only after the retire edge.
    assign bus.data_sram_addr_ok = (count < 2'd2) && !reset;
    assign accept                = bus.data_sram_req && bus.data_sram_addr_ok;
    assign req_out               = req_pipe[LATENCY];
    assign retire                = vld_pipe[LATENCY];
    assign data_ok               = vld_pipe[LATENCY] && !reset;
    assign bus.data_sram_data_ok = data_ok;
    assign bus.data_sram_rdata   = rdata;

    // Decode byte enables and alignment from size and the low address bits.
    always_comb begin
        be      = 4'b0000;
        aligned = 1'b0;
        case (bus.data_sram_size)
            2'd0: begin
                be      = 4'b0001 << bus.data_sram_addr[1:0];
                aligned = 1'b1;
            end
            2'd1: begin
                be      = bus.data_sram_addr[1] ? 4'b1100 : 4'b0011;
                aligned = !bus.data_sram_addr[0];
            end
            2'd2: begin
                be      = 4'b1111;
                aligned = (bus.data_sram_addr[1:0] == 2'b00);
            end
            default: begin
                be      = 4'b0000;
                aligned = 1'b0;
            end
        endcase
    end

    // Pack the sampled request fields for the payload pipeline.
    always_comb begin
        req_in       = '0;
        req_in.wr    = bus.data_sram_wr;
        req_in.ok    = aligned;
        req_in.be    = be;
        req_in.idx   = bus.data_sram_addr[ADDR_W+1:2];
        req_in.wdata = bus.data_sram_wdata;
    end

    // Valid shift register; reset drops every request still in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= '0;
        end else begin
            for (int i = LATENCY; i >= 2; i--) vld_pipe[i] <= vld_pipe[i-1];
            vld_pipe[1] <= accept;
        end
    end

    // Payload shift register; only meaningful where the matching valid bit is set.
    always_ff @(posedge clk) begin
        for (int i = LATENCY; i >= 2; i--) req_pipe[i] <= req_pipe[i-1];
        req_pipe[1] <= req_in;
    end

    // Outstanding-request count; simultaneous accept and retire cancel out.
    always_ff @(posedge clk) begin
        if (reset)                 count <= 2'd0;
        else if (accept && !retire) count <= count + 2'd1;
        else if (!accept && retire) count <= count - 2'd1;
    end

    // Commit writes in the response cycle; gated by data_ok so reset discards them.
    always_ff @(posedge clk) begin
        if (data_ok && req_out.wr && req_out.ok) begin
            for (int b = 0; b < 4; b++) begin
                if (req_out.be[b]) mem[req_out.idx][8*b +: 8] <= req_out.wdata[8*b +: 8];
            end
        end
    end

    // Whole-word read data on an aligned read response, zero otherwise.
    always_comb begin
        rdata = '0;
        if (data_ok && !req_out.wr && req_out.ok) rdata = mem[req_out.idx];
    end

endmodule

// File: tb/tb_data_sram_slave.sv
// Scoreboard bench for data_sram_slave: three instances (LATENCY 1, 2, 3).
// Stimulus pushes hand-computed responses (completion cycle + rdata) into a
// per-instance queue; a negedge monitor pops and compares on every data_ok.
module tb_data_sram_slave;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic rst2;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_on = 1'b0;
    exp_t q1[$];
    exp_t q2[$];
    exp_t q3[$];

    data_sram_if a1();
    data_sram_if a2();
    data_sram_if a3();

    data_sram_slave #(.ADDR_W(10), .LATENCY(1)) u1 (.clk(clk), .reset(rst),  .bus(a1));
    data_sram_slave #(.ADDR_W(10), .LATENCY(2)) u2 (.clk(clk), .reset(rst2), .bus(a2));
    data_sram_slave #(.ADDR_W(10), .LATENCY(3)) u3 (.clk(clk), .reset(rst),  .bus(a3));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic drive(input int d, input logic rq, input logic w, input logic [1:0] sz,
                         input logic [31:0] ad, input logic [31:0] wd);
        case (d)
            1: begin
                a1.data_sram_req = rq; a1.data_sram_wr = w; a1.data_sram_size = sz;
                a1.data_sram_addr = ad; a1.data_sram_wdata = wd;
            end
            2: begin
                a2.data_sram_req = rq; a2.data_sram_wr = w; a2.data_sram_size = sz;
                a2.data_sram_addr = ad; a2.data_sram_wdata = wd;
            end
            default: begin
                a3.data_sram_req = rq; a3.data_sram_wr = w; a3.data_sram_size = sz;
                a3.data_sram_addr = ad; a3.data_sram_wdata = wd;
            end
        endcase
    endtask

    function automatic logic aok(input int d);
        case (d)
            1:       return a1.data_sram_addr_ok;
            2:       return a2.data_sram_addr_ok;
            default: return a3.data_sram_addr_ok;
        endcase
    endfunction

    task automatic push(input int d, input int c, input logic [31:0] v);
        exp_t e;
        e.cyc  = c;
        e.data = v;
        case (d)
            1:       q1.push_back(e);
            2:       q2.push_back(e);
            default: q3.push_back(e);
        endcase
    endtask

    // One-cycle request; must be accepted, response due LATENCY (== d) cycles later.
    task automatic issue(input int d, input logic w, input logic [1:0] sz,
                         input logic [31:0] ad, input logic [31:0] wd, input logic [31:0] exp);
        drive(d, 1'b1, w, sz, ad, wd);
        @(negedge clk);
        chk($sformatf("dut%0d_addr_ok", d), {31'd0, aok(d)}, 32'd1);
        push(d, cyc + d, exp);
        @(posedge clk); #1;
        drive(d, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mon(input int d, input logic dok, input logic [31:0] rd);
        exp_t e;
        int   sz;
        if (dok) begin
            case (d)
                1:       sz = q1.size();
                2:       sz = q2.size();
                default: sz = q3.size();
            endcase
            if (sz == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL dut%0d_spurious_data_ok: got data_ok=1 at cycle %0d, required none", d, cyc);
            end else begin
                case (d)
                    1:       e = q1.pop_front();
                    2:       e = q2.pop_front();
                    default: e = q3.pop_front();
                endcase
                chk($sformatf("dut%0d_rsp_cycle", d), 32'(cyc), 32'(e.cyc));
                chk($sformatf("dut%0d_rsp_rdata", d), rd, e.data);
            end
        end else begin
            chk($sformatf("dut%0d_idle_rdata", d), rd, 32'd0);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            mon(1, a1.data_sram_data_ok, a1.data_sram_rdata);
            mon(2, a2.data_sram_data_ok, a2.data_sram_rdata);
            mon(3, a3.data_sram_data_ok, a3.data_sram_rdata);
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish by 500000, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst  = 1'b1;
        rst2 = 1'b1;
        for (int d = 1; d <= 3; d++) drive(d, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        mon_on = 1'b1;

        // Outputs held at zero during reset.
        @(negedge clk);
        chk("rst_addr_ok1", {31'd0, a1.data_sram_addr_ok}, 32'd0);
        chk("rst_data_ok1", {31'd0, a1.data_sram_data_ok}, 32'd0);
        chk("rst_addr_ok2", {31'd0, a2.data_sram_addr_ok}, 32'd0);
        chk("rst_rdata1",   a1.data_sram_rdata, 32'd0);
        @(posedge clk); #1;
        rst  = 1'b0;
        rst2 = 1'b0;

        // LATENCY=1: first cycle after reset accepts; write then read back-to-back.
        issue(1, 1'b1, 2'd2, 32'h40, 32'h12345678, 32'h0);
        issue(1, 1'b0, 2'd2, 32'h40, 32'h0,        32'h12345678);
        issue(1, 1'b1, 2'd0, 32'h42, 32'h00AA0000, 32'h0);
        issue(1, 1'b0, 2'd2, 32'h40, 32'h0,        32'h12AA5678);
        issue(1, 1'b1, 2'd1, 32'h42, 32'hBEEF0000, 32'h0);
        issue(1, 1'b1, 2'd1, 32'h40, 32'h0000CAFE, 32'h0);
        issue(1, 1'b1, 2'd0, 32'h43, 32'h11000000, 32'h0);
        issue(1, 1'b1, 2'd0, 32'h40, 32'h00000022, 32'h0);
        issue(1, 1'b0, 2'd2, 32'h40, 32'h0,        32'h11EFCA22);
        // Misaligned / reserved-size requests: retire with zero, memory untouched.
        issue(1, 1'b1, 2'd1, 32'h41, 32'hFFFFFFFF, 32'h0);
        issue(1, 1'b1, 2'd2, 32'h42, 32'hFFFFFFFF, 32'h0);
        issue(1, 1'b1, 2'd3, 32'h40, 32'hFFFFFFFF, 32'h0);
        issue(1, 1'b0, 2'd2, 32'h41, 32'h0,        32'h0);
        issue(1, 1'b0, 2'd2, 32'h40, 32'h0,        32'h11EFCA22);
        // Byte read still returns the whole word.
        issue(1, 1'b0, 2'd0, 32'h43, 32'h0,        32'h11EFCA22);
        // Address wrap: bits above the word index are ignored.
        issue(1, 1'b1, 2'd2, 32'h00001000, 32'h5A5A5A5A, 32'h0);
        issue(1, 1'b0, 2'd2, 32'h00000000, 32'h0,        32'h5A5A5A5A);
        issue(1, 1'b1, 2'd2, 32'h00000FFC, 32'hDEADBEEF, 32'h0);
        issue(1, 1'b0, 2'd2, 32'hFFFFFFFC, 32'h0,        32'hDEADBEEF);
        idle(3);

        // LATENCY=3, req held 5 cycles: accept pattern 1,1,0,0,1.
        drive(3, 1'b1, 1'b1, 2'd2, 32'h10, 32'hA5A5A5A5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("l3_hold_addr_ok_%0d", i), {31'd0, a3.data_sram_addr_ok},
                (i == 0 || i == 1 || i == 4) ? 32'd1 : 32'd0);
            if (i == 0 || i == 1 || i == 4) push(3, cyc + 3, 32'h0);
            @(posedge clk); #1;
        end
        drive(3, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        idle(4);
        issue(3, 1'b1, 2'd2, 32'h14, 32'h0BADF00D, 32'h0);
        issue(3, 1'b0, 2'd2, 32'h14, 32'h0,        32'h0BADF00D);
        idle(4);
        issue(3, 1'b0, 2'd2, 32'h10, 32'h0,        32'hA5A5A5A5);
        idle(4);

        // LATENCY=2: two requests in flight killed by reset; the write is dropped.
        issue(2, 1'b1, 2'd2, 32'h20, 32'h33333333, 32'h0);
        idle(3);
        drive(2, 1'b1, 1'b0, 2'd2, 32'h20, 32'h0);
        @(negedge clk);
        chk("l2_kill_accept0", {31'd0, a2.data_sram_addr_ok}, 32'd1);
        @(posedge clk); #1;
        drive(2, 1'b1, 1'b1, 2'd2, 32'h20, 32'h77777777);
        @(negedge clk);
        chk("l2_kill_accept1", {31'd0, a2.data_sram_addr_ok}, 32'd1);
        @(posedge clk); #1;
        drive(2, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        rst2 = 1'b1;
        @(negedge clk);
        chk("l2_rst_data_ok", {31'd0, a2.data_sram_data_ok}, 32'd0);
        chk("l2_rst_addr_ok", {31'd0, a2.data_sram_addr_ok}, 32'd0);
        idle(2);
        rst2 = 1'b0;
        @(negedge clk);
        chk("l2_post_rst_addr_ok", {31'd0, a2.data_sram_addr_ok}, 32'd1);
        @(posedge clk); #1;
        idle(6);
        issue(2, 1'b0, 2'd2, 32'h20, 32'h0, 32'h33333333);
        idle(5);

        chk("q1_drained", 32'(q1.size()), 32'd0);
        chk("q2_drained", 32'(q2.size()), 32'd0);
        chk("q3_drained", 32'(q3.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
